// File: rtl/mag_sq_seq_if.sv
// Start/complete handshake bundle for the sum-of-squares stage.
// The master drives the request and operands. The slave returns
// the idle flag, the result and the one-cycle result strobe.
interface mag_sq_seq_if #(
  parameter int N = 16
);
  logic             start;
  logic [N-1:0]     x;
  logic [N-1:0]     y;
  logic             complete;
  logic [2*N-1:0]   sum;
  logic             sum_start;

  modport master (
    output start, x, y,
    input  complete, sum, sum_start
  );

  modport slave (
    input  start, x, y,
    output complete, sum, sum_start
  );
endinterface

// File: rtl/mag_sq_seq.sv
// Sequential sum of squares: sum = x*x + y*y for signed N-bit operands.
// Each square is built by N shift-add steps, one step per clock.
// Bits are scanned from MSB down to LSB, |x| first and then |y|.
// The final add of |y|'s LSB goes straight into sum, so the result,
// complete and sum_start all appear 2N edges after acceptance.
module mag_sq_seq #(
  parameter int N = 16
) (
  input  logic        clk,
  input  logic        rst,
  mag_sq_seq_if.slave bus
);
  localparam int W  = 2 * N;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_X = 2'd1,
    MUL_Y = 2'd2
  } state_t;

  // Two's-complement magnitude. -2^(N-1) maps to 2^(N-1), which still fits N bits.
  function automatic logic [N-1:0] abs_val(input logic [N-1:0] v);
    logic [N-1:0] r;
    if (v[N-1]) begin
      r = ~v + {{(N-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t         state_r, state_s;
  logic [N-1:0]   ax_r, ax_s;
  logic [N-1:0]   ay_r, ay_s;
  logic [W-1:0]   acc_r, acc_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [W-1:0]   sum_r, sum_s;
  logic           complete_r, complete_s;
  logic           sum_start_r, sum_start_s;

  logic [N-1:0]   cur_op_s;
  logic [W-1:0]   addend_s;
  logic [W-1:0]   step_s;

  // One shift-add step on whichever operand is currently being squared.
  always_comb begin
    cur_op_s = ax_r;
    if (state_r == MUL_Y) begin
      cur_op_s = ay_r;
    end else begin
      cur_op_s = ax_r;
    end
    addend_s = {{N{1'b0}}, cur_op_s} << cnt_r;
    if (cur_op_s[cnt_r]) begin
      step_s = acc_r + addend_s;
    end else begin
      step_s = acc_r;
    end
  end

  // Next-state and next-datapath values. Registers hold unless a state says otherwise.
  always_comb begin
    state_s     = state_r;
    ax_s        = ax_r;
    ay_s        = ay_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    sum_s       = sum_r;
    complete_s  = complete_r;
    sum_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          ax_s       = abs_val(bus.x);
          ay_s       = abs_val(bus.y);
          acc_s      = {W{1'b0}};
          cnt_s      = CNT_MAX;
          complete_s = 1'b0;
          state_s    = MUL_X;
        end else begin
          state_s    = IDLE;
        end
      end
      MUL_X: begin
        acc_s = step_s;
        if (cnt_r == CNT_ZERO) begin
          cnt_s   = CNT_MAX;
          state_s = MUL_Y;
        end else begin
          cnt_s   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
          state_s = MUL_X;
        end
      end
      MUL_Y: begin
        if (cnt_r == CNT_ZERO) begin
          sum_s       = step_s;
          acc_s       = {W{1'b0}};
          complete_s  = 1'b1;
          sum_start_s = 1'b1;
          state_s     = IDLE;
        end else begin
          acc_s   = step_s;
          cnt_s   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
          state_s = MUL_Y;
        end
      end
      default: begin
        acc_s      = {W{1'b0}};
        cnt_s      = CNT_ZERO;
        complete_s = 1'b1;
        state_s    = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ax_r        <= {N{1'b0}};
      ay_r        <= {N{1'b0}};
      acc_r       <= {W{1'b0}};
      cnt_r       <= CNT_ZERO;
      sum_r       <= {W{1'b0}};
      complete_r  <= 1'b1;
      sum_start_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ax_r        <= ax_s;
      ay_r        <= ay_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      sum_r       <= sum_s;
      complete_r  <= complete_s;
      sum_start_r <= sum_start_s;
    end
  end

  assign bus.complete  = complete_r;
  assign bus.sum       = sum_r;
  assign bus.sum_start = sum_start_r;
endmodule

// File: tb/tb_mag_sq_seq.sv
// Scoreboard bench for mag_sq_seq (N=16).
// The stimulus pushes the expected sums into a queue.
// The monitor pops one entry and compares it on every sum_start.
module tb_mag_sq_seq;
  localparam int N = 16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  logic [2*N-1:0] exp_q[$];
  int             pulse_q[$];
  logic [2*N-1:0] last_sum;
  logic           last_ss;

  mag_sq_seq_if #(.N(N)) bus ();

  mag_sq_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter, used to time the result pulses.
  always @(posedge clk) cyc++;

  function automatic logic [2*N-1:0] ref_sum(input logic signed [N-1:0] a,
                                             input logic signed [N-1:0] b);
    longint sa;
    longint sb;
    longint r;
    sa = longint'(a);
    sb = longint'(b);
    r  = sa * sa + sb * sb;
    return r[2*N-1:0];
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: checks results, single-cycle pulses and that sum holds while busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sum_start) begin
        pulse_q.push_back(cyc);
        check("pulse_single", {31'd0, last_ss}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_sum_start", 1, 0);
        end else begin
          check("sum", bus.sum, exp_q.pop_front());
          check("complete_with_pulse", bus.complete, 1);
        end
      end
      if (!bus.complete) begin
        check("sum_stable_busy", bus.sum, last_sum);
      end
    end
    last_sum = bus.sum;
    last_ss  = bus.sum_start;
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (!bus.complete && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!bus.complete) check("wait_idle_timeout", 0, 1);
  endtask

  // Pulses start for one cycle, optionally pushing the expected sum.
  task automatic issue(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                       input bit push);
    @(negedge clk);
    bus.x     = a;
    bus.y     = b;
    bus.start = 1'b1;
    if (push) exp_q.push_back(ref_sum(a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges from acceptance until complete rises again.
  task automatic wait_done_lat(input int req_lat);
    int k;
    k = 0;
    check("busy_after_accept", bus.complete, 0);
    while (!bus.complete && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", k, req_lat);
  endtask

  typedef struct {
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic [2*N-1:0]      s;
  } vec_t;

  vec_t vecs[5];

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    last_sum  = '0;
    last_ss   = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.x     = 16'sd3;
    bus.y     = 16'sd4;

    // Hand-computed directed vectors.
    vecs[0] = '{16'sd3,      16'sd4,      32'd25};
    vecs[1] = '{-16'sd32768, -16'sd32768, 32'h8000_0000};
    vecs[2] = '{16'sd32767,  16'sd32767,  32'd2147352578};
    vecs[3] = '{16'sd0,      16'sd0,      32'd0};
    vecs[4] = '{-16'sd5,     16'sd12,     32'd169};

    // Reset state, with start asserted during reset: reset must win.
    repeat (3) @(posedge clk);
    #1;
    check("rst_complete", bus.complete, 1);
    check("rst_sum", bus.sum, 0);
    check("rst_sum_start", bus.sum_start, 0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, each with a latency check.
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      @(negedge clk);
      bus.x     = vecs[i].a;
      bus.y     = vecs[i].b;
      bus.start = 1'b1;
      exp_q.push_back(vecs[i].s);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done_lat(2 * N);
    end

    // A start while busy is ignored: the result stays 169.
    wait_idle();
    @(negedge clk);
    bus.x     = vecs[4].a;
    bus.y     = vecs[4].b;
    bus.start = 1'b1;
    exp_q.push_back(vecs[4].s);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    issue(16'sd1, 16'sd1, 1'b0);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("ignored_start_still_idle", bus.complete, 1);
    check("ignored_start_sum", bus.sum, 169);

    // Reset 15 cycles into an operation aborts it, with no pulse.
    issue(16'sd100, 16'sd100, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_complete", bus.complete, 1);
    check("abort_sum", bus.sum, 0);
    check("abort_sum_start", bus.sum_start, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_sum_after", bus.sum, 0);
    issue(16'sd6, 16'sd8, 1'b1);
    wait_done_lat(2 * N);

    // Start held high: three results of 50, one every 2N+1 cycles.
    repeat (2) @(posedge clk);
    pulse_q.delete();
    @(negedge clk);
    bus.x     = 16'sd7;
    bus.y     = 16'sd1;
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'd50);
    @(posedge clk);
    repeat (2 * (2 * N + 1)) @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x     = 16'sd1;
    bus.y     = 16'sd1;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("held_pulse_count", pulse_q.size(), 3);
    if (pulse_q.size() == 3) begin
      check("held_period_1", pulse_q[1] - pulse_q[0], 2 * N + 1);
      check("held_period_2", pulse_q[2] - pulse_q[1], 2 * N + 1);
    end

    // Random signed pairs against the reference model.
    for (int i = 0; i < 1000; i++) begin
      logic signed [N-1:0] ra;
      logic signed [N-1:0] rb;
      ra = N'($urandom);
      rb = N'($urandom);
      wait_idle();
      issue(ra, rb, 1'b1);
      bus.x = N'($urandom);
      bus.y = N'($urandom);
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
